// File: rtl/delay_module.sv
// Single-tap echo for the 12-bit audio path: 8192-entry circular buffer,
// tap D*256 samples back, halved and mixed with the dry sample (2-cycle latency).
module delay_module (
    input  logic        clock,
    input  logic        reset,
    input  logic        ready,
    input  logic [11:0] incoming_sample,
    input  logic [4:0]  delay_amount,
    output logic [11:0] modified_sample,
    output logic        done,
    output logic [12:0] current_pointer,
    output logic [12:0] delayed_pointer
);
    localparam logic [12:0] FILL_MAX = 13'd8191;

    logic [11:0]        buffer_mem [0:8191];
    logic [11:0]        ram_q;
    logic               accept;
    logic               stage1_valid;
    logic               stage2_valid;
    logic [11:0]        x1_reg;
    logic [11:0]        x2_reg;
    logic [11:0]        tap_reg;
    logic               bypass1_reg;
    logic               bypass2_reg;
    logic               tap_ok_reg;
    logic [12:0]        filled;
    logic [12:0]        delay_offset;
    logic signed [13:0] twice_sum;
    logic [11:0]        mix_value;

    assign delay_offset    = {delay_amount, 8'd0};
    assign delayed_pointer = current_pointer - delay_offset;
    assign accept          = reset && ready && !stage1_valid && !stage2_valid;

    // Block RAM, read-first: a same-address read returns the word being replaced.
    always_ff @(posedge clock) begin
        if (accept) begin
            buffer_mem[current_pointer] <= incoming_sample;
            ram_q                       <= buffer_mem[delayed_pointer];
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            x1_reg      <= incoming_sample;
            bypass1_reg <= (delay_amount == 5'd0);
            tap_ok_reg  <= (filled >= delay_offset);
        end
        if (stage1_valid) begin
            x2_reg      <= x1_reg;
            bypass2_reg <= bypass1_reg;
            tap_reg     <= tap_ok_reg ? ram_q : 12'd0;
        end
    end

    // Summing 2x + d and dropping the LSB equals x + (d >>> 1) without losing tap bits.
    assign twice_sum = $signed({x2_reg[11], x2_reg, 1'b0}) + $signed({{2{tap_reg[11]}}, tap_reg});

    always_comb begin
        mix_value = twice_sum[12:1];
        if (bypass2_reg) begin
            mix_value = x2_reg;
        end else if (twice_sum >= 14'sd4096) begin
            mix_value = 12'h7FF;
        end else if (twice_sum < -14'sd4096) begin
            mix_value = 12'h800;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            stage1_valid    <= 1'b0;
            stage2_valid    <= 1'b0;
            done            <= 1'b0;
            modified_sample <= 12'd0;
            current_pointer <= 13'd0;
            filled          <= 13'd0;
        end else begin
            stage1_valid <= accept;
            stage2_valid <= stage1_valid;
            done         <= stage2_valid;
            if (stage2_valid) begin
                modified_sample <= mix_value;
                current_pointer <= current_pointer + 13'd1;
                if (filled != FILL_MAX) begin
                    filled <= filled + 13'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_delay_module.sv
// Randomized self-checking bench for delay_module: a sample-history model
// predicts every output pulse; literal expectations pin the model.
module tb_delay_module;
    logic        clock = 1'b0;
    logic        reset;
    logic        ready;
    logic [11:0] incoming_sample;
    logic [4:0]  delay_amount;
    logic [11:0] modified_sample;
    logic        done;
    logic [12:0] current_pointer;
    logic [12:0] delayed_pointer;

    delay_module dut (
        .clock           (clock),
        .reset           (reset),
        .ready           (ready),
        .incoming_sample (incoming_sample),
        .delay_amount    (delay_amount),
        .modified_sample (modified_sample),
        .done            (done),
        .current_pointer (current_pointer),
        .delayed_pointer (delayed_pointer)
    );

    always #5 clock = ~clock;

    typedef struct {
        int due;
        int y;
        int cp;
    } exp_t;

    exp_t q[$];
    int   hist [0:16383];
    int   n       = 0;
    int   cyc     = 0;
    int   last_y  = 0;
    int   checks  = 0;
    int   errors  = 0;
    bit   checking = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d, sample %0d)", name, act, exp, cyc, n);
        end
    endfunction

    function automatic int sms();
        return int'($signed(modified_sample));
    endfunction

    // Sample k is echoed from sample k - D*256, provided that sample exists since reset.
    function automatic int model_push(input int x, input int d);
        int dd;
        int s;
        int y;
        dd = 0;
        if (d == 0) begin
            y = x;
        end else begin
            if (n >= d * 256) dd = hist[n - d * 256];
            s = x + (dd >>> 1);
            y = (s > 2047) ? 2047 : ((s < -2048) ? -2048 : s);
        end
        hist[n] = x;
        n++;
        q.push_back('{cyc + 3, y, n % 8192});
        return y;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // junk=1 holds ready high into the busy cycle with a different sample; it must be ignored.
    task automatic send(input int x, input int d, input int gap, input bit junk, output int y);
        y = model_push(x, d);
        ready           = 1'b1;
        incoming_sample = 12'(x);
        delay_amount    = 5'(d);
        tick();
        if (junk) incoming_sample = 12'($urandom);
        else      ready = 1'b0;
        tick();
        ready = 1'b0;
        for (int i = 2; i < gap; i++) tick();
    endtask

    task automatic do_reset();
        checking = 1'b0;
        reset    = 1'b0;
        ready    = 1'b0;
        repeat (2) tick();
        reset  = 1'b1;
        n      = 0;
        last_y = 0;
        q.delete();
        checking = 1'b1;
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(4095)) - 2048;
    endfunction

    task automatic run_impulse(input int gap);
        int y;
        for (int k = 0; k < 260; k++) begin
            send((k == 0) ? 1000 : 0, 1, gap, 1'b0, y);
            if (k == 0) begin
                chk("imp_model_s0", y, 1000);
                chk("imp_dut_s0", sms(), 1000);
            end else if (k == 256) begin
                chk("imp_model_s256", y, 500);
                chk("imp_dut_s256", sms(), 500);
            end else begin
                chk("imp_model_zero", y, 0);
            end
        end
        chk("imp_dut_s259", sms(), 0);
    endtask

    always @(negedge clock) begin
        bit   exp_done;
        exp_t e;
        if (checking) begin
            exp_done = (q.size() > 0) && (q[0].due == cyc);
            chk("done", int'(done), int'(exp_done));
            if (exp_done) begin
                e      = q.pop_front();
                last_y = e.y;
                chk("current_pointer", int'(current_pointer), e.cp);
                chk("delayed_pointer", int'(delayed_pointer), (e.cp - int'(delay_amount) * 256) & 8191);
            end
            while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
            chk("modified_sample", sms(), last_y);
        end
    end

    initial begin
        int y;
        int x;
        reset           = 1'b0;
        ready           = 1'b0;
        incoming_sample = 12'd0;
        delay_amount    = 5'd0;
        repeat (3) tick();
        chk("reset_done", int'(done), 0);
        chk("reset_sample", sms(), 0);
        chk("reset_cp", int'(current_pointer), 0);
        do_reset();

        run_impulse(64);
        $display("scenario impulse_d1_gap64: errors so far %0d", errors);

        for (int k = 0; k < 200; k++) begin
            x = $rtoi(900.0 * $sin(2.0 * 3.14159265 * k / 48.0) + 700.0 * $sin(2.0 * 3.14159265 * 5.0 * k / 48.0));
            send(x, 0, int'($urandom_range(3, 6)), 1'b0, y);
            chk("bypass_model", y, x);
        end
        $display("scenario bypass_d0: errors so far %0d", errors);

        do_reset();
        for (int k = 0; k < 300; k++) begin
            send(2000, 1, 3, 1'b0, y);
            if (k == 255) chk("sat_pos_model_s255", y, 2000);
            if (k == 256) chk("sat_pos_model_s256", y, 2047);
        end
        chk("sat_pos_dut", sms(), 2047);
        do_reset();
        for (int k = 0; k < 300; k++) begin
            send(-2000, 1, 3, 1'b0, y);
            if (k == 0)   chk("sat_neg_model_s0", y, -2000);
            if (k == 256) chk("sat_neg_model_s256", y, -2048);
        end
        chk("sat_neg_dut", sms(), -2048);
        $display("scenario saturation: errors so far %0d", errors);

        do_reset();
        for (int k = 0; k < 8200; k++) begin
            send(rnd_sample(), 1, 3, ($urandom_range(7) == 0), y);
            if (k == 8191) chk("wrap_cp0", int'(current_pointer), 0);
            if (k == 8196) begin
                chk("wrap_cp5", int'(current_pointer), 5);
                chk("wrap_dp7941", int'(delayed_pointer), 7941);
            end
        end
        $display("scenario wrap_8200: errors so far %0d", errors);

        do_reset();
        for (int k = 0; k < 7940; k++) begin
            x = rnd_sample();
            send(x, 31, 3, ($urandom_range(15) == 0), y);
            if (k == 7935) chk("d31_model_gated", y, x);
        end
        $display("scenario fill_gating_d31: errors so far %0d", errors);

        do_reset();
        for (int k = 0; k < 540; k++) begin
            send((k == 10 || k == 20) ? 800 : 0, (k < 300) ? 1 : 2, 3, 1'b0, y);
            if (k == 266) chk("dchg_model_s266", y, 400);
            if (k == 276) chk("dchg_model_s276", y, 400);
            if (k == 522) chk("dchg_model_s522", y, 400);
            if (k == 300) chk("dchg_model_s300", y, 0);
        end
        chk("dchg_dut_end", sms(), 0);
        $display("scenario delay_change: errors so far %0d", errors);

        ready           = 1'b1;
        incoming_sample = 12'd1234;
        delay_amount    = 5'd0;
        tick();
        ready    = 1'b0;
        reset    = 1'b0;
        checking = 1'b0;
        tick();
        chk("midrst_done_a", int'(done), 0);
        tick();
        chk("midrst_done_b", int'(done), 0);
        tick();
        chk("midrst_done_c", int'(done), 0);
        chk("midrst_sample", sms(), 0);
        chk("midrst_cp", int'(current_pointer), 0);
        do_reset();
        run_impulse(3);
        $display("scenario reset_mid_op_then_impulse: errors so far %0d", errors);

        repeat (6) tick();
        chk("pending_outputs", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/delay_module.md
# delay_module

Single-tap echo (delay) effect for the 12-bit audio sample path. Each accepted sample is stored in an 8192-entry circular buffer. The sample from `delay_amount × 256` samples earlier is read back, attenuated by half and mixed with the dry input. The block sits between the sample source (one `ready` strobe per sample period) and downstream effects or DAC logic.

## Interface
Parameters: none. Buffer depth is fixed at 8192 × 12 bits (13-bit addresses); one delay step is fixed at 256 samples.

Reset: one clock; reset is synchronous and active-low. The port is named `reset` (active when 0, sampled only on rising `clock`).

- `clock`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset
- `ready`  in  1  one-cycle strobe: `incoming_sample` is valid this cycle
- `incoming_sample`  in  12  signed two's-complement dry sample
- `delay_amount`  in  5  delay D in steps of 256 samples (0..31 → 0..7936 samples)
- `modified_sample`  out  12  signed mixed output, registered
- `done`  out  1  one-cycle pulse: `modified_sample` updated
- `current_pointer`  out  13  buffer write address for the next sample, registered
- `delayed_pointer`  out  13  read address, combinational: (`current_pointer` − D·256) mod 8192

## Operation
- Storage: 8192 × 12 synchronous single-port-write / registered-read RAM (block RAM). Contents are not cleared at reset.
- Fill counter `filled`: 13 bits, counts stored samples, saturates at 8191. The delayed tap is valid only when `filled` ≥ D·256; otherwise the delayed value is forced to 0. This makes power-up output deterministic.
- On an accepted `ready`:
  - Latch `incoming_sample` (x) and `delay_amount` (D).
  - Write x at `current_pointer`.
  - Read at `delayed_pointer` (read-first: a same-address read returns the old word).
- Mix:
  - D = 0: bypass, y = x.
  - Otherwise, with d = delayed word (or 0 if invalid): y = sat12(x + (d >>> 1)). Use arithmetic shift. Form the sum at 13 bits, then clamp to [−2048, +2047].
- After the mix completes:
  - `current_pointer` increments mod 8192 (8191 → 0).
  - `filled` increments (saturating).
- `delay_amount` may change at any time. It takes effect at the next accepted `ready`. `delayed_pointer` tracks the live input combinationally.

## Timing
- Reset (`reset` = 0 at a rising edge):
  - Outputs: `modified_sample` = 0, `done` = 0, `current_pointer` = 0.
  - Internal: `filled` = 0, pipeline idle.
  - Any in-flight sample is discarded with no `done`.
- Pipeline, for `ready` sampled high at edge N:
  - N: RAM write; read address registered; x and D latched.
  - N+1: read data valid.
  - N+2: `modified_sample`, `current_pointer` and `filled` update; `done` is high during the cycle after N+2.
  - Latency: 2 cycles from the `ready` edge to output.
- `ready` spacing must be ≥ 3 cycles. A `ready` asserted while the pipeline is busy (cycles N+1, N+2) is ignored, with no write and no `done`. The normal system rate is one `ready` per 64 cycles.
- `modified_sample` holds its value between `done` pulses.
- Reset has priority over `ready` in the same cycle.

## Test plan
- Impulse, D=1, `ready` every 64 cycles: input 1000 at sample 0, then 0s. Required output: 1000 at sample 0, 500 at sample 256, 0 elsewhere. `done` pulses once per sample, 2 cycles after `ready`.
- Bypass, D=0: 1 kHz + 5 kHz mixed test signal. Required: `modified_sample` equals `incoming_sample` exactly, every sample.
- Saturation, D=1:
  - Constant +2000 → samples 0–255 give 2000; from sample 256 onward 2000+1000 clamps to 2047.
  - Constant −2000 → clamps to −2048.
- Wrap: run 8200 samples with D=1.
  - `current_pointer` goes 8191 → 0 at sample 8192.
  - With `current_pointer` = 5, `delayed_pointer` = 7941.
  - Echo stays 256 samples behind across the wrap.
- Fill gating:
  - D=31 right after reset: delayed contribution is 0 for the first 7936 samples.
  - Change D from 1 to 2 mid-stream: the new echo spacing applies from the next `ready`.
- Reset mid-operation: assert `reset`=0 at cycle N+1 of a sample.
  - No `done`; all outputs 0; `current_pointer` restarts at 0.
  - The following impulse test repeats the first scenario exactly.
